// File: rtl/ls_pkg.sv
// ls_pkg: shared state encoding, default widths and test-pattern function for ls_traffic_gen.
package ls_pkg;
   localparam int LS_ADDR_W = 32;
   localparam int LS_DATA_W = 32;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} tg_state_e;
   // Pattern is seed XOR address; callers zero-extend to 64 bits and truncate the result.
   function automatic logic [63:0] gen_data(input logic [63:0] seed, input logic [63:0] addr);
      return seed ^ addr;
   endfunction
endpackage

// File: rtl/ls_traffic_gen_if.sv
// ls_traffic_gen_if: load-store request/response link; master is the initiator, slave the subsystem.
interface ls_traffic_gen_if import ls_pkg::*; #(
   parameter int ADDR_WIDTH = LS_ADDR_W,
   parameter int DATA_WIDTH = LS_DATA_W
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_error;
   modport master (
      output req_valid, req_wr, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );
   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/ls_traffic_gen.sv
// ls_traffic_gen: write-then-read-back BIST initiator for the load-store link.
// Define LS_TG_TIMEOUT_EN to add a response watchdog that aborts the run after TIMEOUT_CYCLES.
module ls_traffic_gen import ls_pkg::*; #(
   parameter int ADDR_WIDTH     = LS_ADDR_W,
   parameter int DATA_WIDTH     = LS_DATA_W,
   parameter int NUM_WORDS      = 16,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DATA_WIDTH-1:0] seed,
   ls_traffic_gen_if.master      bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_exp,
   output logic [DATA_WIDTH-1:0] fail_got,
   output logic                  timeout
);
   localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;

   if (NUM_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("ls_traffic_gen: NUM_WORDS and TIMEOUT_CYCLES must be >= 1");
   end

   tg_state_e             state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, req_addr_q, req_addr_d, fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d, req_wdata_q, req_wdata_d;
   logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
   logic [CNT_WIDTH-1:0]  err_q, err_d;
   logic                  req_valid_q, req_valid_d, req_wr_q, req_wr_d, resp_ready_q, resp_ready_d;
   logic                  done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
   logic                  hit, fin, last;
   logic [DATA_WIDTH-1:0] got;
`ifdef LS_TG_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            waiting;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      base_d      = base_q;
      seed_d      = seed_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_got_d  = fail_got_q;
      done_d      = done_q;
      pass_d      = pass_q;
      tmo_d       = tmo_q;
      hit         = 1'b0;
      fin         = 1'b0;
      got         = '0;
      last        = idx_q == IDX_W'(NUM_WORDS - 1);
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d     = WR_REQ;
            idx_d       = '0;
            base_d      = base_addr;
            seed_d      = seed;
            err_d       = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            tmo_d       = 1'b0;
         end
         WR_REQ: if (bus.req_ready) state_d = WR_RESP;
         WR_RESP: if (bus.resp_valid) begin
            hit     = bus.resp_error;
            state_d = last ? RD_REQ : WR_REQ;
            idx_d   = last ? '0 : idx_q + 1'b1;
         end
         RD_REQ: if (bus.req_ready) state_d = RD_RESP;
         RD_RESP: if (bus.resp_valid) begin
            hit     = bus.resp_error || bus.resp_rdata != req_wdata_q;
            got     = bus.resp_rdata;
            fin     = last;
            state_d = last ? DONE : RD_REQ;
            idx_d   = last ? '0 : idx_q + 1'b1;
         end
         default: ;
      endcase
`ifdef LS_TG_TIMEOUT_EN
      waiting = ((state_q == WR_REQ || state_q == RD_REQ) && !bus.req_ready) ||
                ((state_q == WR_RESP || state_q == RD_RESP) && !bus.resp_valid);
      wd_d    = waiting ? wd_q + 1'b1 : '0;
      if (waiting && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
         hit     = 1'b1;
         fin     = 1'b1;
         tmo_d   = 1'b1;
         state_d = DONE;
         wd_d    = '0;
      end
`endif
      // req_addr_q/req_wdata_q still describe the transaction in flight, so they double as the expectation.
      if (hit) begin
         if (err_q == '0) begin
            fail_addr_d = req_addr_q;
            fail_exp_d  = req_wdata_q;
            fail_got_d  = got;
         end
         err_d = err_q + CNT_WIDTH'(~&err_q);
      end
      if (fin) begin
         done_d = 1'b1;
         pass_d = err_d == '0;
      end
      req_valid_d  = state_d == WR_REQ || state_d == RD_REQ;
      req_wr_d     = state_d == WR_REQ;
      resp_ready_d = state_d == WR_RESP || state_d == RD_RESP;
      req_addr_d   = base_d + (ADDR_WIDTH'(idx_d) << 2);
      req_wdata_d  = DATA_WIDTH'(gen_data(64'(seed_d), 64'(req_addr_d)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         base_q       <= '0;
         seed_q       <= '0;
         err_q        <= '0;
         fail_addr_q  <= '0;
         fail_exp_q   <= '0;
         fail_got_q   <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         tmo_q        <= 1'b0;
         req_valid_q  <= 1'b0;
         req_wr_q     <= 1'b0;
         resp_ready_q <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         seed_q       <= seed_d;
         err_q        <= err_d;
         fail_addr_q  <= fail_addr_d;
         fail_exp_q   <= fail_exp_d;
         fail_got_q   <= fail_got_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         tmo_q        <= tmo_d;
         req_valid_q  <= req_valid_d;
         req_wr_q     <= req_wr_d;
         resp_ready_q <= resp_ready_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
      end
   end

`ifdef LS_TG_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`endif

   assign bus.req_valid  = req_valid_q;
   assign bus.req_wr     = req_wr_q;
   assign bus.req_addr   = req_addr_q;
   assign bus.req_wdata  = req_wdata_q;
   assign bus.resp_ready = resp_ready_q;
   assign busy           = state_q != IDLE && state_q != DONE;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign fail_addr      = fail_addr_q;
   assign fail_exp       = fail_exp_q;
   assign fail_got       = fail_got_q;
   assign timeout        = tmo_q;
endmodule

// File: tb/tb_ls_traffic_gen.sv
// tb_ls_traffic_gen: randomized scoreboard bench with a behavioural memory responder.
module tb_ls_traffic_gen;
   import ls_pkg::*;
   localparam int AW = 32, DW = 32, NW = 4, CW = 16, TO = 16;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, pass, timeout;
   logic [CW-1:0] err_count;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_exp, fail_got;

   ls_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ls_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_WIDTH(CW),
                    .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .seed(seed), .bus(bus),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
      .fail_exp(fail_exp), .fail_got(fail_got), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
   req_t          exp_q[$];
   int            checks = 0, failures = 0;
   int            bp_mode = 0;
   bit            bad_en = 0, werr_en = 0, mute = 0;
   logic [AW-1:0] bad_addr = '0, werr_addr = '0;
   logic [DW-1:0] mem [logic [AW-1:0]];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
      end
   endtask

   // Responder: zero or more stall cycles per request, then a delayed response from a memory model.
   initial begin : responder
      bit            req_hs = 0, resp_hs = 0, pend = 0;
      int            stall = 0, dly = 0;
      req_t          cur;
      logic          perr;
      logic [DW-1:0] pdata;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_error = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_hs = 0; resp_hs = 0; pend = 0;
            bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_error = 1'b0;
            continue;
         end
         if (resp_hs) begin
            bus.resp_valid = 1'b0;
            bus.resp_error = 1'b0;
         end
         if (req_hs) begin
            if (cur.wr) mem[cur.addr] = cur.data;
            pdata = cur.wr ? '0 : (bad_en && cur.addr == bad_addr) ? 32'hDEAD_BEEF :
                    mem.exists(cur.addr) ? mem[cur.addr] : '0;
            perr  = werr_en && cur.wr && cur.addr == werr_addr;
            pend  = !mute;
            dly   = $urandom_range(0, 2);
         end
         if (pend) begin
            if (dly == 0) begin
               bus.resp_valid = 1'b1; bus.resp_rdata = pdata; bus.resp_error = perr; pend = 0;
            end else dly--;
         end
         if (!bus.req_valid) begin
            bus.req_ready = 1'b0;
            stall = bp_mode != 0 ? 5 : $urandom_range(0, 2);
         end else if (stall == 0) bus.req_ready = 1'b1;
         else begin
            bus.req_ready = 1'b0;
            stall--;
         end
         req_hs  = bus.req_valid && bus.req_ready;
         cur     = '{bus.req_wr, bus.req_addr, bus.req_wdata};
         resp_hs = bus.resp_valid && bus.resp_ready;
      end
   end

   // Monitor: every accepted request is popped from the scoreboard; stalled requests must hold.
   initial begin : monitor
      req_t cur, prev, e;
      bit   stalled = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            stalled = 0;
            continue;
         end
         cur = '{bus.req_wr, bus.req_addr, bus.req_wdata};
         if (bus.req_valid) begin
            if (stalled) chk("req_hold", cur, prev);
            if (bus.req_ready) begin
               stalled = 0;
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_req got=%0h exp=none", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("req", cur, e);
               end
            end else begin
               stalled = 1;
               prev = cur;
            end
         end else stalled = 0;
      end
   end

   task automatic start_run(input logic [AW-1:0] b, input logic [DW-1:0] s);
      logic [AW-1:0] a;
      exp_q.delete();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NW; i++) begin
            a = b + AW'(4 * i);
            exp_q.push_back('{p == 0, a, s ^ DW'(a)});
         end
      @(negedge clk);
      base_addr = b; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("busy_after_start", busy, 1);
      chk("done_cleared", done, 0);
      chk("err_cleared", err_count, 0);
   endtask

   task automatic run(input logic [AW-1:0] b, input logic [DW-1:0] s, input int bp,
                      input int bad_i, input int werr_i);
      int            errs = 0;
      logic [AW-1:0] fa = '0;
      logic [DW-1:0] fe = '0, fg = '0;
      bp_mode   = bp;
      bad_en    = bad_i >= 0;
      bad_addr  = b + AW'(4 * bad_i);
      werr_en   = werr_i >= 0;
      werr_addr = b + AW'(4 * werr_i);
      if (werr_en) begin
         errs++; fa = werr_addr; fe = s ^ DW'(werr_addr); fg = '0;
      end
      if (bad_en && (s ^ DW'(bad_addr)) != 32'hDEAD_BEEF) begin
         if (errs == 0) begin
            fa = bad_addr; fe = s ^ DW'(bad_addr); fg = 32'hDEAD_BEEF;
         end
         errs++;
      end
      start_run(b, s);
      for (int n = 0; n < 1000 && !done; n++) @(negedge clk);
      chk("done", done, 1);
      chk("pass", pass, errs == 0);
      chk("err_count", err_count, CW'(errs));
      chk("busy_at_done", busy, 0);
      chk("timeout", timeout, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      if (errs > 0) begin
         chk("fail_addr", fail_addr, fa);
         chk("fail_exp", fail_exp, fe);
         chk("fail_got", fail_got, fg);
      end
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin : main
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_resp_ready", bus.resp_ready, 0);
      chk("rst_status", {busy, done, pass, timeout}, 0);
      chk("rst_err_fail", {err_count, fail_addr, fail_exp, fail_got}, 0);
      chk("rst_req_bus", {bus.req_wr, bus.req_addr, bus.req_wdata}, 0);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1 chk("idle_no_req", bus.req_valid, 0);
      end
      run(32'h100, 32'hA5A5_0000, 0, -1, -1);
      run(32'h100, 32'hA5A5_0000, 0, 2, -1);
      run(32'h200, 32'h1234_5678, 1, -1, -1);
      run(32'h300, 32'h0F0F_0F0F, 0, -1, 1);
      run(32'h300, 32'h0F0F_0F0F, 0, -1, -1);
      bp_mode = 0; bad_en = 0; werr_en = 0;
      start_run(32'h400, $urandom);
      for (int n = 0; n < 500 && !(bus.req_valid && !bus.req_wr); n++) @(negedge clk);
      chk("reached_read_pass", bus.req_valid && !bus.req_wr, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req_valid", bus.req_valid, 0);
      chk("async_rst_resp_ready", bus.resp_ready, 0);
      chk("async_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      run(32'h400, $urandom, 0, -1, -1);
      run(32'hFFFF_FFF8, $urandom, 0, 3, -1);
      repeat (8)
         run($urandom, $urandom, $urandom_range(0, 1),
             $urandom_range(0, 2) == 0 ? int'($urandom_range(0, NW - 1)) : -1,
             $urandom_range(0, 3) == 0 ? int'($urandom_range(0, NW - 1)) : -1);
`ifdef LS_TG_TIMEOUT_EN
      bp_mode = 0; bad_en = 0; werr_en = 0; mute = 1;
      start_run(32'h500, 32'h5555_AAAA);
      for (int n = 0; n < 200 && !done; n++) @(negedge clk);
      chk("tmo_done", done, 1);
      chk("tmo_flag", timeout, 1);
      chk("tmo_pass", pass, 0);
      chk("tmo_err_count", err_count, 1);
      mute = 0;
      exp_q.delete();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ls_traffic_gen.md
Name: ls_traffic_gen

Overview:
- Synthesizable initiator for the load-store subsystem request/response interface.
- Drives the same req_*/resp_* handshake that load_store_top accepts; it is the master end of that link.
- On start, runs one write pass over NUM_WORDS words, then a read-back pass, and checks every returned word.
- Reports pass/fail, error count and the first failing transaction; used as on-chip BIST and as a bring-up traffic source.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width
- NUM_WORDS, 16, words per pass (>=1)
- CNT_WIDTH, 16, width of error counter
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with LS_TG_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle run request
- base_addr  in  ADDR_WIDTH  start address, latched on accepted start
- seed  in  DATA_WIDTH  pattern seed, latched on accepted start
- req_valid  out  1  request valid
- req_ready  in  1  subsystem accepts request
- req_wr  out  1  1=write, 0=read
- req_addr  out  ADDR_WIDTH  request address
- req_wdata  out  DATA_WIDTH  write data
- resp_valid  in  1  response valid
- resp_ready  out  1  generator accepts response
- resp_rdata  in  DATA_WIDTH  read data
- resp_error  in  1  response error flag
- busy  out  1  run in progress
- done  out  1  run finished, held until next start
- pass  out  1  valid when done; 1 = zero errors
- err_count  out  CNT_WIDTH  mismatches plus resp_error responses, saturating
- fail_addr  out  ADDR_WIDTH  address of first failure
- fail_exp  out  DATA_WIDTH  expected data at first failure
- fail_got  out  DATA_WIDTH  returned data at first failure
- timeout  out  1  watchdog fired (tied 0 without macro)

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: every output 0; state IDLE; index 0.
- States:
  - IDLE: start -> WR_REQ; latch base_addr and seed; clear err_count, fail_*, done, pass, timeout.
  - WR_REQ: req_valid=1, req_wr=1. On req_valid&&req_ready -> WR_RESP.
  - WR_RESP: resp_ready=1. On resp_valid: if resp_error, count the error. Then if idx==NUM_WORDS-1 -> RD_REQ with idx=0; else idx++ -> WR_REQ.
  - RD_REQ: req_valid=1, req_wr=0. On handshake -> RD_RESP.
  - RD_RESP: resp_ready=1. On resp_valid: error if resp_error or resp_rdata != expected. Then last word -> DONE; else idx++ -> RD_REQ.
  - DONE: done=1; pass=(err_count==0). start -> restart exactly as from IDLE.
- Address and data:
  - addr = base_addr + (idx<<2), modulo 2^ADDR_WIDTH (wraps silently).
  - data = seed ^ addr (addr zero-extended or truncated to DATA_WIDTH).
- Handshake:
  - One transaction outstanding at a time.
  - req_* are registered and held stable while req_valid=1 and req_ready=0.
  - req_valid deasserts in the cycle after the handshake.
  - Minimum 2 cycles per transaction with zero-wait responders.
  - resp_ready=0 outside the RESP states; responses arriving then are ignored.
- First failure: fail_addr/exp/got capture only when err_count transitions from 0. For a write-pass resp_error, fail_exp=data and fail_got=0.
- Saturation: err_count saturates at all-ones.
- start while busy: ignored.
- busy = state not IDLE and not DONE.
- Reset asserted mid-run: req_valid and resp_ready drop asynchronously; the run is abandoned.

Optional Feature:
- Macro LS_TG_TIMEOUT_EN.
- Defined: a counter runs in WR_RESP/RD_RESP and in the REQ states while req_ready=0. If it reaches TIMEOUT_CYCLES: timeout=1, err_count+1, -> DONE with pass=0. The counter clears on each handshake.
- Undefined: no counter; timeout tied 0; the generator waits indefinitely.

Decomposition:
- Package ls_pkg:
  - tg_state_e enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE).
  - Default ADDR_WIDTH/DATA_WIDTH constants.
  - Pattern function gen_data(seed, addr).
- No sub-module needed; the watchdog counter stays inline under the macro.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0, state IDLE; deassert, no start -> req_valid stays 0.
- Clean run: NUM_WORDS=4, base 0x100, seed 0xA5A5_0000, paired with load_store_top -> 4 writes to 0x100..0x10C with data 0xA5A5_0100..0xA5A5_010C, then 4 reads; done=1, pass=1, err_count=0.
- Corruption: behavioural responder returns 0xDEAD_BEEF for 0x108 -> err_count=1, fail_addr=0x108, fail_exp=0xA5A5_0108, fail_got=0xDEAD_BEEF, pass=0.
- Backpressure: req_ready low for 5 cycles per request -> req_addr/req_wdata stable throughout; the run still passes.
- resp_error on the 2nd write, then start again -> first run err_count=1; the restart clears counters and passes.
- Reset mid read pass, then start -> req_valid falls immediately; the new run completes with pass=1. With LS_TG_TIMEOUT_EN, TIMEOUT_CYCLES=16 and a responder that never answers -> timeout=1 after 16 cycles, done=1, pass=0.
